// File: rtl/sobel_ctrl_pkg.sv
// Shared types, widths and the clamped threshold step used by the Sobel threshold controller.
package sobel_ctrl_pkg;

  localparam int unsigned CNT_W_DEFAULT = 24;
  localparam int unsigned THRESH_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    CALC,
    APPLY
  } state_e;

  // One-bit-wider arithmetic so that both overflow and underflow clamp cleanly.
  function automatic logic [THRESH_W-1:0] clamp_step(
    input logic [THRESH_W-1:0] cur,
    input logic [THRESH_W-1:0] step,
    input logic                up,
    input logic [THRESH_W-1:0] lo,
    input logic [THRESH_W-1:0] hi
  );
    logic [THRESH_W:0] sum;
    if (up) begin
      sum = {1'b0, cur} + {1'b0, step};
      clamp_step = (sum > {1'b0, hi}) ? hi : sum[THRESH_W-1:0];
    end else begin
      sum = {1'b0, cur} - {1'b0, step};
      clamp_step = (sum[THRESH_W] || (sum < {1'b0, lo})) ? lo : sum[THRESH_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sobel_edge_counter.sv
// Saturating event counter with synchronous clear; clear takes priority over increment.
module sobel_edge_counter
  import sobel_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: assign the default first so every path drives cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sobel_thresh_ctrl.sv
// Frame-synchronous threshold controller for the Sobel edge detector (manual staging or closed-loop step).
// Optional line/pixel geometry check enabled by SOBEL_THRESH_CTRL_LINE_CHK_EN.
module sobel_thresh_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter int unsigned          CNT_W       = CNT_W_DEFAULT,
  parameter logic [15:0]          IMG_HDISP   = 16'd640,
  parameter logic [15:0]          IMG_VDISP   = 16'd480,
  parameter logic [THRESH_W-1:0]  THRESH_INIT = 8'd64,
  parameter logic [THRESH_W-1:0]  THRESH_MIN  = 8'd16,
  parameter logic [THRESH_W-1:0]  THRESH_MAX  = 8'd200,
  parameter logic [THRESH_W-1:0]  STEP        = 8'd4,
  parameter logic [CNT_W-1:0]     HYST        = CNT_W'(256)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_wr,
  input  logic [THRESH_W-1:0] cfg_thresh,
  input  logic                cfg_auto_en,
  input  logic [CNT_W-1:0]    cfg_target_cnt,
  input  logic                det_vsync,
  input  logic                det_href,
  input  logic                det_clken,
  input  logic                det_bit,
  output logic [THRESH_W-1:0] thresh,
  output logic [CNT_W-1:0]    frame_edge_cnt,
  output logic                frame_done,
  output logic                busy
`ifdef SOBEL_THRESH_CTRL_LINE_CHK_EN
  ,
  output logic                frame_err
`endif
);

  state_e              state_q, state_d;
  logic                vsync_q, armed_q;
  logic                rise_pend_q, rise_pend_d;
  logic                pending_q, pending_d;
  logic                used_q, used_d;
  logic [THRESH_W-1:0] staged_q, staged_d;
  logic [THRESH_W-1:0] next_q, next_d;
  logic [THRESH_W-1:0] thresh_q, thresh_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  logic                done_q, done_d;
  logic                cnt_clr, cnt_inc;
  logic [CNT_W-1:0]    cnt;
  logic                rise, fall, start, step_ok;
  logic                cnt_above, cnt_below;

  // armed_q blocks a false rise when reset releases in the middle of an active frame.
  assign rise  = det_vsync & ~vsync_q & armed_q;
  assign fall  = ~det_vsync & vsync_q;
  assign start = (state_q == IDLE) && (rise || rise_pend_q);

  assign cnt_above = {1'b0, cnt} > ({1'b0, cfg_target_cnt} + {1'b0, HYST});
  assign cnt_below = ({1'b0, cnt} + {1'b0, HYST}) < {1'b0, cfg_target_cnt};

  sobel_edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (cnt)
  );

`ifdef SOBEL_THRESH_CTRL_LINE_CHK_EN
  logic        href_q, bad_q, err_q;
  logic [15:0] lines_q, px_q;
  logic        line_err;

  assign line_err = bad_q || (lines_q != IMG_VDISP);
  assign step_ok  = ~line_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_q  <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      lines_q <= '0;
      px_q    <= '0;
    end else begin
      href_q <= det_href;
      if (start) begin
        lines_q <= '0;
        px_q    <= '0;
        bad_q   <= 1'b0;
      end else if (state_q == FRAME) begin
        if (det_href && !href_q) begin
          lines_q <= lines_q + 16'd1;
          px_q    <= det_clken ? 16'd1 : 16'd0;
        end else if (det_href && det_clken) begin
          px_q <= px_q + 16'd1;
        end
        if (!det_href && href_q && (px_q != IMG_HDISP)) bad_q <= 1'b1;
      end
      if (state_q == APPLY) err_q <= line_err;
    end
  end

  assign frame_err = err_q;
`else
  logic unused_line_params;
  assign unused_line_params = ^{IMG_HDISP, IMG_VDISP};
  assign step_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    rise_pend_d = rise_pend_q;
    pending_d   = pending_q;
    used_d      = used_q;
    staged_d    = staged_q;
    next_d      = next_q;
    thresh_d    = thresh_q;
    fcnt_d      = fcnt_q;
    done_d      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;

    if (cfg_wr) begin
      staged_d  = cfg_thresh;
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FRAME;
          cnt_clr     = 1'b1;
          rise_pend_d = 1'b0;
        end
      end
      FRAME: begin
        cnt_inc = det_vsync & det_href & det_clken & det_bit;
        if (fall) state_d = CALC;
      end
      CALC: begin
        rise_pend_d = rise_pend_q | rise;
        used_d      = 1'b1;
        if (cfg_wr) begin
          next_d = cfg_thresh;
        end else if (pending_q) begin
          next_d = staged_q;
        end else begin
          used_d = 1'b0;
          if (cfg_auto_en && step_ok && cnt_above)
            next_d = clamp_step(thresh_q, STEP, 1'b1, THRESH_MIN, THRESH_MAX);
          else if (cfg_auto_en && step_ok && cnt_below)
            next_d = clamp_step(thresh_q, STEP, 1'b0, THRESH_MIN, THRESH_MAX);
          else
            next_d = thresh_q;
        end
        state_d = APPLY;
      end
      APPLY: begin
        rise_pend_d = rise_pend_q | rise;
        thresh_d    = next_q;
        fcnt_d      = cnt;
        done_d      = 1'b1;
        if (used_q && !cfg_wr) pending_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b0;
      armed_q     <= 1'b0;
      rise_pend_q <= 1'b0;
      pending_q   <= 1'b0;
      used_q      <= 1'b0;
      staged_q    <= THRESH_INIT;
      next_q      <= THRESH_INIT;
      thresh_q    <= THRESH_INIT;
      fcnt_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= det_vsync;
      armed_q     <= armed_q | ~det_vsync;
      rise_pend_q <= rise_pend_d;
      pending_q   <= pending_d;
      used_q      <= used_d;
      staged_q    <= staged_d;
      next_q      <= next_d;
      thresh_q    <= thresh_d;
      fcnt_q      <= fcnt_d;
      done_q      <= done_d;
    end
  end

  assign thresh         = thresh_q;
  assign frame_edge_cnt = fcnt_q;
  assign frame_done     = done_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_sobel_thresh_ctrl.sv
// Self-checking bench: directed and randomized frames against a frame-level threshold model.
module tb_sobel_thresh_ctrl;

  localparam int TINIT = 64;
  localparam int TMIN  = 16;
  localparam int TMAX  = 200;
  localparam int STEP  = 4;
  localparam int HYST  = 2;
  localparam int SAT   = 15;

  logic        clk = 1'b0;
  logic        rst_n, cfg_wr, cfg_auto_en;
  logic        det_vsync, det_href, det_clken, det_bit;
  logic [7:0]  cfg_thresh;
  logic [23:0] cfg_target_cnt;
  logic [7:0]  thresh, s_thresh;
  logic [23:0] frame_edge_cnt;
  logic [3:0]  s_cnt;
  logic        frame_done, busy, s_done, s_busy;

  int n_checks = 0;
  int n_fails  = 0;

  // Frame-level reference state.
  int m_thresh, m_staged, m_target;
  bit m_pending, m_auto;

  always #5 clk = ~clk;

  sobel_thresh_ctrl #(.CNT_W(24), .HYST(24'd2)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_wr         (cfg_wr),
    .cfg_thresh     (cfg_thresh),
    .cfg_auto_en    (cfg_auto_en),
    .cfg_target_cnt (cfg_target_cnt),
    .det_vsync      (det_vsync),
    .det_href       (det_href),
    .det_clken      (det_clken),
    .det_bit        (det_bit),
    .thresh         (thresh),
    .frame_edge_cnt (frame_edge_cnt),
    .frame_done     (frame_done),
    .busy           (busy)
  );

  sobel_thresh_ctrl #(.CNT_W(4), .HYST(4'd2)) u_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_wr         (1'b0),
    .cfg_thresh     (8'd0),
    .cfg_auto_en    (1'b0),
    .cfg_target_cnt (4'd0),
    .det_vsync      (det_vsync),
    .det_href       (det_href),
    .det_clken      (det_clken),
    .det_bit        (det_bit),
    .thresh         (s_thresh),
    .frame_edge_cnt (s_cnt),
    .frame_done     (s_done),
    .busy           (s_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_decide(input int cnt);
    if (m_pending) begin
      m_thresh  = m_staged;
      m_pending = 1'b0;
    end else if (m_auto && (cnt > m_target + HYST)) begin
      m_thresh = (m_thresh + STEP > TMAX) ? TMAX : m_thresh + STEP;
    end else if (m_auto && (cnt + HYST < m_target)) begin
      m_thresh = (m_thresh - STEP < TMIN) ? TMIN : m_thresh - STEP;
    end
  endfunction

  task automatic write_cfg(input int v);
    @(negedge clk);
    cfg_wr     = 1'b1;
    cfg_thresh = 8'(v);
    @(negedge clk);
    cfg_wr = 1'b0;
    m_staged  = v;
    m_pending = 1'b1;
  endtask

  task automatic set_auto(input bit en, input int target);
    m_auto         = en;
    m_target       = target;
    cfg_auto_en    = en;
    cfg_target_cnt = 24'(target);
  endtask

  // wr_phase: 0 none, 1 mid-frame, 2 during CALC, 3 during APPLY.
  task automatic run_frame(input int w, input int h, input int pct, input int wr_phase,
                           input int wr_val, input bit started, input bit b2b);
    int cnt = 0;
    if (!started) begin
      @(negedge clk);
      det_vsync = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) begin
        @(negedge clk);
        det_href  = 1'b1;
        det_clken = 1'b1;
        det_bit   = ($urandom_range(99) < pct);
        cnt += int'(det_bit);
        cfg_wr = (wr_phase == 1) && (l == h / 2) && (p == 0);
        cfg_thresh = 8'(wr_val);
      end
      repeat (2) begin
        @(negedge clk);
        det_href = 1'b0;
        det_bit  = 1'b0;
        cfg_wr   = 1'b0;
      end
      if (wr_phase == 1 && l == h / 2) check("thresh_hold_midframe", thresh, m_thresh);
    end
    @(negedge clk);
    det_vsync = 1'b0;
    if (wr_phase == 1 || wr_phase == 2) begin
      m_staged  = wr_val;
      m_pending = 1'b1;
    end
    model_decide(cnt);
    @(negedge clk);
    check("done_low_calc", frame_done, 0);
    check("busy_calc", busy, 1);
    if (wr_phase == 2) begin
      cfg_wr     = 1'b1;
      cfg_thresh = 8'(wr_val);
    end
    @(negedge clk);
    cfg_wr = 1'b0;
    check("done_low_apply", frame_done, 0);
    if (wr_phase == 3) begin
      cfg_wr     = 1'b1;
      cfg_thresh = 8'(wr_val);
    end
    if (b2b) det_vsync = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    if (wr_phase == 3) begin
      m_staged  = wr_val;
      m_pending = 1'b1;
    end
    check("done_pulse", frame_done, 1);
    check("thresh", thresh, m_thresh);
    check("edge_cnt", frame_edge_cnt, cnt);
    check("sat_cnt", s_cnt, (cnt > SAT) ? SAT : cnt);
    check("sat_done", s_done, 1);
    check("sat_thresh", s_thresh, TINIT);
    check("busy_idle", busy, 0);
    @(negedge clk);
    check("done_one_cycle", frame_done, 0);
    check("busy_b2b", busy, b2b);
  endtask

  initial begin
    bit started, b2b;
    int seen, ph;
    rst_n = 1'b0;
    cfg_wr = 1'b0; cfg_thresh = 8'd0;
    det_vsync = 1'b0; det_href = 1'b0; det_clken = 1'b0; det_bit = 1'b0;
    set_auto(1'b0, 0);
    m_thresh = TINIT; m_staged = 0; m_pending = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_thresh", thresh, TINIT);
    check("rst_cnt", frame_edge_cnt, 0);
    check("rst_done", frame_done, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", s_busy, 0);

    // Manual mode: full 16x4 frame of edges, then a staged mid-frame write.
    run_frame(16, 4, 100, 0, 0, 1'b0, 1'b0);
    check("first_frame_cnt64", frame_edge_cnt, 64);
    run_frame(16, 4, 50, 1, 100, 1'b0, 1'b0);
    check("manual_100", thresh, 100);
    run_frame(8, 2, 50, 0, 0, 1'b0, 1'b0);
    check("manual_keeps_100", thresh, 100);

    // Auto mode: step up once, then step down to the lower clamp.
    write_cfg(64);
    set_auto(1'b1, 10);
    run_frame(4, 1, 0, 0, 0, 1'b0, 1'b0);
    run_frame(10, 4, 100, 0, 0, 1'b0, 1'b0);
    check("auto_up_68", thresh, 68);
    for (int i = 0; i < 15; i++) run_frame(4, 1, 0, 0, 0, 1'b0, 1'b0);
    check("clamp_min", thresh, TMIN);

    // Upper clamp from 198.
    write_cfg(198);
    run_frame(4, 1, 0, 0, 0, 1'b0, 1'b0);
    run_frame(10, 4, 100, 0, 0, 1'b0, 1'b0);
    check("clamp_max", thresh, TMAX);

    // Writes landing in CALC and in APPLY.
    run_frame(10, 4, 100, 2, 50, 1'b0, 1'b0);
    check("calc_write", thresh, 50);
    run_frame(10, 4, 100, 3, 120, 1'b0, 1'b0);
    check("apply_write_autostep", thresh, 54);
    run_frame(10, 4, 100, 0, 0, 1'b0, 1'b0);
    check("apply_write_next", thresh, 120);

    // Rise during APPLY must start the next frame.
    run_frame(6, 2, 70, 0, 0, 1'b0, 1'b1);
    run_frame(6, 2, 70, 0, 0, 1'b1, 1'b0);

    // Randomized frames.
    started = 1'b0;
    for (int i = 0; i < 14; i++) begin
      set_auto(1'($urandom_range(1)), int'($urandom_range(40)));
      ph  = ($urandom_range(1) == 1) ? int'($urandom_range(3)) : 0;
      b2b = (i < 13) ? 1'($urandom_range(1)) : 1'b0;
      run_frame(int'($urandom_range(12, 1)), int'($urandom_range(4, 1)),
                int'($urandom_range(100)), ph, int'($urandom_range(255)), started, b2b);
      started = b2b;
    end

    // Reset mid-frame, release with vsync high: that frame is ignored.
    set_auto(1'b0, 0);
    @(negedge clk);
    det_vsync = 1'b1;
    repeat (2) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      det_href = 1'b1; det_clken = 1'b1; det_bit = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_thresh", thresh, TINIT);
    check("midrst_done", frame_done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cnt", frame_edge_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_thresh = TINIT; m_pending = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (frame_done || busy) seen++;
      det_href  = (k < 20);
      det_bit   = 1'b1;
      det_vsync = (k < 24);
    end
    det_href = 1'b0; det_bit = 1'b0;
    check("ignored_frame", seen, 0);
    run_frame(5, 3, 100, 0, 0, 1'b0, 1'b0);
    check("post_reset_cnt", frame_edge_cnt, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
